// File: rtl/wbc_vec_fetch.sv
// rtl/wbc_vec_fetch.sv - interrupt entry sequencer: VIC vector handshake, then PC/PSW fetch over Wishbone
module wbc_vec_fetch #(
    parameter int          TMO   = 255,
    parameter logic [15:0] VMASK = 16'o177776
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        vic_irq_i,
    input  logic [15:0] vic_dat_i,
    output logic        vic_stb_o,
    input  logic        vic_ack_i,
    input  logic        take_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_src_o,
    output logic [15:0] vec_o,
    output logic [15:0] pc_o,
    output logic [15:0] psw_o,
    output logic [15:0] wbm_adr_o,
    input  logic [15:0] wbm_dat_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i
);
    localparam int CW = $clog2(TMO + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_VREQ  = 3'd1;
    localparam logic [2:0] S_RDPC  = 3'd2;
    localparam logic [2:0] S_RDPSW = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          tmo;
    logic [15:0]   vec_masked;

    assign tmo        = (cnt == CW'(TMO));
    assign vec_masked = vic_dat_i & VMASK;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            vic_stb_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            err_src_o <= 2'b00;
            vec_o     <= 16'd0;
            pc_o      <= 16'd0;
            psw_o     <= 16'd0;
            wbm_adr_o <= 16'd0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            cnt    <= cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (take_i && vic_irq_i) begin
                        state     <= S_VREQ;
                        vic_stb_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                // ack beats a withdrawn request, which beats the timeout
                S_VREQ: begin
                    if (vic_ack_i) begin
                        vec_o     <= vec_masked;
                        vic_stb_o <= 1'b0;
                        wbm_adr_o <= vec_masked;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cnt       <= '0;
                        state     <= S_RDPC;
                    end else if (!vic_irq_i) begin
                        vic_stb_o <= 1'b0;
                        busy_o    <= 1'b0;
                        cnt       <= '0;
                        state     <= S_IDLE;
                    end else if (tmo) begin
                        vic_stb_o <= 1'b0;
                        busy_o    <= 1'b0;
                        err_o     <= 1'b1;
                        err_src_o <= 2'b01;
                        cnt       <= '0;
                        state     <= S_IDLE;
                    end
                end
                S_RDPC: begin
                    if (wbm_ack_i) begin
                        pc_o      <= wbm_dat_i;
                        wbm_adr_o <= vec_o + 16'd2;
                        cnt       <= '0;
                        state     <= S_RDPSW;
                    end else if (tmo) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        busy_o    <= 1'b0;
                        err_o     <= 1'b1;
                        err_src_o <= 2'b10;
                        cnt       <= '0;
                        state     <= S_IDLE;
                    end
                end
                S_RDPSW: begin
                    if (wbm_ack_i) begin
                        psw_o     <= wbm_dat_i;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        done_o    <= 1'b1;
                        cnt       <= '0;
                        state     <= S_DONE;
                    end else if (tmo) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        busy_o    <= 1'b0;
                        err_o     <= 1'b1;
                        err_src_o <= 2'b11;
                        cnt       <= '0;
                        state     <= S_IDLE;
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    cnt    <= '0;
                    state  <= S_IDLE;
                end
                default: begin
                    vic_stb_o <= 1'b0;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    busy_o    <= 1'b0;
                    cnt       <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wbc_vec_fetch.sv
// tb/tb_wbc_vec_fetch.sv - randomized check of wbc_vec_fetch against a transaction-level outcome model
module tb_wbc_vec_fetch;
    localparam int          TMO   = 15;
    localparam logic [15:0] VMASK = 16'o177776;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vic_irq = 1'b0;
    logic [15:0] vic_dat = 16'd0;
    logic        vic_stb;
    logic        vic_ack = 1'b0;
    logic        take = 1'b0;
    logic        busy, done, err;
    logic [1:0]  err_src;
    logic [15:0] vec, pc, psw, wbm_adr;
    logic [15:0] wbm_dat = 16'd0;
    logic        wbm_cyc, wbm_stb;
    logic        wbm_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [15:0] mem [0:32767];
    logic [1:0]  last_src = 2'b00;

    always #5 clk = ~clk;

    wbc_vec_fetch #(.TMO(TMO), .VMASK(VMASK)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .vic_irq_i(vic_irq), .vic_dat_i(vic_dat), .vic_stb_o(vic_stb), .vic_ack_i(vic_ack),
        .take_i(take), .busy_o(busy), .done_o(done), .err_o(err), .err_src_o(err_src),
        .vec_o(vec), .pc_o(pc), .psw_o(psw),
        .wbm_adr_o(wbm_adr), .wbm_dat_i(wbm_dat), .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb),
        .wbm_ack_i(wbm_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // vd/pd/sd: cycles each responder waits before acking; anything above TMO never acks in time
    task automatic run_seq(input int vd, input int pd, input int sd, input logic [15:0] vraw);
        int vcnt = 0, mcnt = 0, phase = 0, done_cyc = -1;
        bit got_done = 0, got_err = 0, vack_prev = 0;
        logic [15:0] psw_adr = 16'hxxxx;
        logic [1:0]  src_seen = 2'b00;
        logic [15:0] v_seen = 0, pc_seen = 0, psw_seen = 0;
        logic [15:0] exp_vec, exp_psw_adr;
        logic [1:0]  exp_src;
        bit          exp_err;

        exp_vec     = vraw & VMASK;
        exp_psw_adr = exp_vec + 16'd2;
        exp_err     = (vd > TMO) || (pd > TMO) || (sd > TMO);
        exp_src     = (vd > TMO) ? 2'b01 : (pd > TMO) ? 2'b10 : 2'b11;

        vic_irq = 1'b1;
        take    = 1'b1;
        @(posedge clk); #1;
        take = 1'b0;
        for (int c = 0; c < 100 && !got_done && !got_err; c++) begin
            if (vack_prev) check("vic_stb_drop", vic_stb, 1'b0);
            vack_prev = 0;
            vic_ack = 1'b0;
            wbm_ack = 1'b0;
            vic_dat = 16'($urandom);
            if (vic_stb) begin
                if (vcnt == vd) begin
                    vic_ack = 1'b1;
                    vic_dat = vraw;
                    vack_prev = 1;
                end
                vcnt++;
            end
            if (wbm_cyc && wbm_stb) begin
                if (mcnt == ((phase == 0) ? pd : sd)) begin
                    wbm_ack = 1'b1;
                    wbm_dat = mem[wbm_adr[15:1]];
                    if (phase == 1) psw_adr = wbm_adr;
                    mcnt = 0;
                    phase++;
                end else begin
                    mcnt++;
                end
            end
            @(posedge clk); #1;
            if (done) begin
                got_done = 1; done_cyc = c;
                v_seen = vec; pc_seen = pc; psw_seen = psw;
            end
            if (err) begin
                got_err = 1; src_seen = err_src;
            end
        end
        vic_ack = 1'b0;
        wbm_ack = 1'b0;

        if (exp_err) begin
            check("err_pulse", got_err, 1'b1);
            check("err_src", src_seen, exp_src);
            check("no_done_on_err", got_done, 1'b0);
            check("idle_after_err", {vic_stb, wbm_cyc, wbm_stb, busy}, 4'b0);
            last_src = exp_src;
        end else begin
            check("done_pulse", got_done, 1'b1);
            check("vec", v_seen, exp_vec);
            check("pc", pc_seen, mem[exp_vec[15:1]]);
            check("psw", psw_seen, mem[exp_psw_adr[15:1]]);
            check("psw_adr", psw_adr, exp_psw_adr);
            check("err_src_held", err_src, last_src);
            if (vd == 0 && pd == 0 && sd == 0) check("min_latency", done_cyc, 2);
            @(posedge clk); #1;
            check("done_one_cycle", {done, busy}, 2'b00);
        end
    endtask

    function automatic int rand_delay();
        int r = $urandom_range(0, 9);
        if (r == 9) return TMO + 1 + $urandom_range(0, 3);
        if (r == 8) return TMO;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        bit bad;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[16'o060 >> 1] = 16'o001000;
        mem[16'o062 >> 1] = 16'o000340;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {vic_stb, busy, done, err, err_src, vec, pc, psw, wbm_adr, wbm_cyc, wbm_stb}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_seq(2, 0, 0, 16'o000060);

        bad = 0;
        vic_irq = 1'b1;
        take = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (vic_stb || wbm_cyc || busy) bad = 1;
        end
        check("no_take_idle", bad, 1'b0);

        run_seq(TMO + 5, 0, 0, 16'o000100);
        run_seq(1, 1, TMO + 5, 16'o000200);
        run_seq(0, 0, 0, 16'o000200);
        run_seq(1, 0, 0, 16'o177777);
        run_seq(TMO, TMO, TMO, 16'o000444);

        // reset asserted mid-cycle while the PC read is outstanding
        vic_irq = 1'b1;
        take = 1'b1;
        @(posedge clk); #1;
        take = 1'b0;
        vic_ack = 1'b1;
        vic_dat = 16'o000060;
        @(posedge clk); #1;
        vic_ack = 1'b0;
        check("rdpc_before_reset", wbm_cyc, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_reset", {vic_stb, busy, done, err, err_src, vec, pc, psw, wbm_adr, wbm_cyc, wbm_stb}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_src = 2'b00;
        run_seq(0, 1, 2, 16'o000060);

        // request withdrawn while waiting for the vector
        vic_irq = 1'b1;
        take = 1'b1;
        @(posedge clk); #1;
        take = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vic_irq = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (err || done) bad = 1;
        end
        check("withdraw_silent", bad, 1'b0);
        check("withdraw_idle", {vic_stb, busy}, 2'b00);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] v;
            v = (t % 8 == 7) ? 16'o177777 : 16'($urandom);
            run_seq(rand_delay(), rand_delay(), rand_delay(), v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
